// File: rtl/looper_pkg.sv
// Shared types and constants for the looper datapath: key width, valid key range, track count, FSM states.
// Pure declarations; no logic, no latency, no flow control.
package looper_pkg;

  localparam int KEY_W   = 8;
  localparam int KEY_MAX = 26;
  localparam int TRACKS  = 8;

  typedef enum logic [1:0] {IDLE, PLAY, REC, CLEAR} state_t;

  function automatic logic key_valid(input logic [KEY_W-1:0] key);
    return (key != '0) && (key <= KEY_W'(KEY_MAX));
  endfunction

endpackage

// File: rtl/loop_mem.sv
// TRACKS x STEPS key store: one synchronous write port, combinational read of every track at one step.
// Write lands on the clock edge; read is same-cycle; no flow control, always accepts.
module loop_mem
  import looper_pkg::*;
#(
  parameter int STEPS = 16,
  parameter int SW    = $clog2(STEPS)
) (
  input  logic                      CLOCK_50,
  input  logic                      we,
  input  logic [$clog2(TRACKS)-1:0] wr_trk,
  input  logic [SW-1:0]             wr_step,
  input  logic [KEY_W-1:0]          wr_dat,
  input  logic [SW-1:0]             rd_step,
  output logic [TRACKS*KEY_W-1:0]   rd_dat
);

  // No reset: loop contents survive a reset and are only erased by CLEAR.
  logic [KEY_W-1:0] mem [TRACKS][STEPS];

  always_ff @(posedge CLOCK_50) begin
    if (we) mem[wr_trk][wr_step] <= wr_dat;
  end

  always_comb begin
    rd_dat = '0;
    for (int t = 0; t < TRACKS; t++) rd_dat[t*KEY_W +: KEY_W] = mem[t][rd_step];
  end

endmodule

// File: rtl/beat_loop_sequencer.sv
// Eight-track step looper with overdub; drives the packed keyNum bus one cycle after step, write or key change.
// No backpressure: the audio stage samples keyNum every cycle, and live keys are sampled unconditionally.
module beat_loop_sequencer #(
  parameter int TRACKS      = 8,
  parameter int STEPS       = 16,
  parameter int STEP_CYCLES = 6_250_000
) (
  input  logic                     CLOCK_50,
  input  logic                     rst,
  input  logic [7:0]               key_in,
  input  logic [2:0]               track_sel,
  input  logic                     play_en,
  input  logic                     rec_en,
  input  logic                     clear_track,
  output logic [TRACKS*8-1:0]      keyNum,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_tick,
  output logic                     busy,
  output logic                     recording
);

  import looper_pkg::*;

  localparam int SW = $clog2(STEPS);
  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] BEAT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

  state_t state, state_nxt;

  logic [CW-1:0]          beat_cnt;
  logic [SW-1:0]          clr_cnt;
  logic [2:0]             clr_trk;
  logic [KEY_W-1:0]       key_now, key_hold, rec_dat;
  logic                   running, tc;
  logic                   wr_en;
  logic [2:0]             wr_trk;
  logic [SW-1:0]          wr_step;
  logic [KEY_W-1:0]       wr_dat;
  logic [TRACKS*8-1:0]    rd_dat, bus_nxt;

  loop_mem #(.STEPS(STEPS)) u_mem (
    .CLOCK_50 (CLOCK_50),
    .we       (wr_en),
    .wr_trk   (wr_trk),
    .wr_step  (wr_step),
    .wr_dat   (wr_dat),
    .rd_step  (step_idx),
    .rd_dat   (rd_dat)
  );

  always_comb begin
    key_now   = key_valid(key_in) ? key_in : '0;
    running   = (state == PLAY) || (state == REC);
    tc        = running && (beat_cnt == BEAT_LAST);
    step_tick = tc;

    state_nxt = state;
    case (state)
      IDLE:    if (clear_track) state_nxt = CLEAR;
               else if (play_en) state_nxt = PLAY;
      PLAY:    if (!play_en) state_nxt = IDLE;
               else if (rec_en) state_nxt = REC;
      REC:     if (!play_en) state_nxt = IDLE;
               else if (!rec_en) state_nxt = PLAY;
      CLEAR:   if (clr_cnt == STEP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // A key still held at the terminal cycle counts even if key_hold has not caught it yet.
    rec_dat = (key_now != '0) ? key_now : key_hold;
    wr_en   = 1'b0;
    wr_trk  = track_sel;
    wr_step = step_idx;
    wr_dat  = rec_dat;
    if (state == CLEAR) begin
      wr_en   = !rst;
      wr_trk  = clr_trk;
      wr_step = clr_cnt;
      wr_dat  = '0;
    end else if (state == REC && tc && play_en && rec_dat != '0) begin
      wr_en = !rst;
    end

    bus_nxt = '0;
    case (state)
      PLAY: bus_nxt = rd_dat;
      REC: begin
        bus_nxt = rd_dat;
        bus_nxt[int'(track_sel)*KEY_W +: KEY_W] = key_now;
      end
      IDLE:    bus_nxt[int'(track_sel)*KEY_W +: KEY_W] = key_now;
      default: bus_nxt = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      step_idx  <= '0;
      clr_cnt   <= '0;
      clr_trk   <= '0;
      key_hold  <= '0;
      keyNum    <= '0;
      busy      <= 1'b0;
      recording <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == CLEAR);
      recording <= (state_nxt == REC);
      keyNum    <= bus_nxt;

      if (state == IDLE && state_nxt == PLAY) begin
        beat_cnt <= '0;
        step_idx <= '0;
      end else if (tc) begin
        beat_cnt <= '0;
        step_idx <= step_idx + 1'b1;
      end else if (running) begin
        beat_cnt <= beat_cnt + 1'b1;
      end

      if (state_nxt != REC || tc) key_hold <= '0;
      else if (state == REC && key_now != '0) key_hold <= key_now;

      // Target track is latched so track_sel may change freely during the clear.
      if (state == IDLE && state_nxt == CLEAR) begin
        clr_trk <= track_sel;
        clr_cnt <= '0;
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

endmodule
